dmem_access_unit: RTL

Memory-stage data-memory sequencer for the 5-stage pipeline. It takes load/store requests from the EX/MEM register outputs and runs a request/acknowledge transaction with a variable-latency data memory. It produces the load data feeding the MEM/WB register's read-data input. It also generates the pipeline write-enable that holds MEM/WB, and all upstream pipeline registers, until the access completes.

---
 rtl/dmem_access_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// Memory-stage data-memory sequencer: runs one req/ack transaction per load/store
// and stalls the pipeline until the access completes, times out, or is dropped.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rd_data,
    output logic        pipe_write_en,
    output logic        align_err,
    output logic        bus_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               req_nx, we_nx, align_nx, bus_nx;
    logic [31:0]        addr_nx, wdata_nx, rd_nx;
    logic               access, aligned;

    assign access  = ex_mem_read | ex_mem_write;
    assign aligned = (ex_addr[1:0] == 2'b00);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_data   <= '0;
            align_err <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            mem_req   <= req_nx;
            mem_we    <= we_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            rd_data   <= rd_nx;
            align_err <= align_nx;
            bus_err   <= bus_nx;
        end
    end

    // Next-state, next-register values and the combinational stall
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        req_nx        = mem_req;
        we_nx         = mem_we;
        addr_nx       = mem_addr;
        wdata_nx      = mem_wdata;
        rd_nx         = rd_data;
        align_nx      = 1'b0;
        bus_nx        = 1'b0;
        pipe_write_en = 1'b1;

        case (state)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        pipe_write_en = 1'b0;
                        addr_nx       = {ex_addr[31:2], 2'b00};
                        wdata_nx      = ex_wdata;
                        we_nx         = ex_mem_write;
                        req_nx        = 1'b1;
                        cnt_nx        = '0;
                        state_nx      = BUSY;
                    end else begin
                        rd_nx    = '0;
                        align_nx = 1'b1;
                    end
                end
            end
            BUSY: begin
                pipe_write_en = 1'b0;
                // An ack in the expiry cycle still completes the access normally
                if (mem_ack) begin
                    rd_nx    = mem_we ? 32'h0 : mem_rdata;
                    req_nx   = 1'b0;
                    state_nx = DONE;
                end else if (cnt == CNT_LAST) begin
                    rd_nx    = mem_we ? 32'h0 : ERR_DATA;
                    req_nx   = 1'b0;
                    bus_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
